// File: rtl/fanout_fork_buffer.sv
// Registered ready/valid fork: buffers up to DEPTH tokens and delivers the head
// token exactly once to every active branch, popping it when all have taken it.
module fanout_fork_buffer #(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_OUT    = 7,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [NUM_OUT-1:0]    en,
  input  logic [NUM_OUT-1:0]    sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_OUT-1:0]    valid_out,
  input  logic [NUM_OUT-1:0]    ready_in
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [NUM_OUT-1:0]    done;

  logic [NUM_OUT-1:0] active, take;
  logic               head_valid, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign active     = en & sel;
  assign head_valid = (count != '0);
  // Producer ready depends only on occupancy, so a full buffer stays closed
  // even when the head pops in the same cycle.
  assign ready_out  = (count < FULL_CNT);
  assign push       = valid_in & ready_out;
  assign data_out   = mem[rd_ptr];
  assign valid_out  = {NUM_OUT{head_valid}} & active & ~done;
  assign take       = valid_out & ready_in;
  // Inactive branches and branches already served never hold the head back.
  assign pop        = head_valid & (&(~active | done | ready_in));

  // NOTE: all sequential state is updated with non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
        done   <= '0;
      end else begin
        done <= done | take;
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // NOTE: storage is reset here only because data_out must read zero out of
  // reset; flush leaves the contents alone since they are unreachable afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Self-checking bench for fanout_fork_buffer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fanout_fork_buffer;

  localparam int DW    = 17;
  localparam int NO    = 7;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [NO-1:0] en, sel;
  logic [DW-1:0] data_out;
  logic [NO-1:0] valid_out;
  logic [NO-1:0] ready_in;

  fanout_fork_buffer #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .en(en), .sel(sel),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO of tokens plus the set of branches already served.
  logic [DW-1:0] q[$];
  logic [NO-1:0] served;

  task automatic model_compare(input string tag);
    logic [NO-1:0] exp_v;
    exp_v = (q.size() > 0) ? (en & sel & ~served) : '0;
    check({tag, " ready_out"}, 32'(ready_out), 32'(q.size() < DEPTH));
    check({tag, " valid_out"}, 32'(valid_out), 32'(exp_v));
    if (q.size() > 0) check({tag, " data_out"}, 32'(data_out), 32'(q[0]));
  endtask

  task automatic model_edge();
    logic [NO-1:0] act;
    logic          can_push, all_served;
    if (flush) begin
      q.delete();
      served = '0;
    end else begin
      act      = en & sel;
      can_push = valid_in && (q.size() < DEPTH);
      if (q.size() > 0) begin
        all_served = 1'b1;
        for (int i = 0; i < NO; i++)
          if (act[i] && !served[i] && !ready_in[i]) all_served = 1'b0;
        if (all_served) begin
          void'(q.pop_front());
          served = '0;
        end else begin
          served = served | (act & ready_in);
        end
      end
      if (can_push) q.push_back(data_in);
    end
  endtask

  // Inputs are driven just after the falling edge; outputs are sampled 1 ns later.
  task automatic settle(input string tag);
    #1;
    model_compare(tag);
  endtask

  task automatic advance();
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic vin, input logic [DW-1:0] d, input logic [NO-1:0] e,
                       input logic [NO-1:0] s, input logic [NO-1:0] r, input logic f);
    valid_in = vin; data_in = d; en = e; sel = s; ready_in = r; flush = f;
  endtask

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic [NO-1:0] rdy;
    logic          exp_ro;
    logic [NO-1:0] exp_vo;
    logic [DW-1:0] exp_do;
    logic          chk_do;
  } vec_t;

  vec_t vecs[17];
  int   rx0;

  initial begin
    // Broadcast stream followed by fill/backpressure/drain, all branches active.
    vecs[0] = '{1'b1, 17'h1, 7'h7F, 1'b1, 7'h00, 17'h0, 1'b0};
    for (int k = 1; k <= 7; k++)
      vecs[k] = '{1'b1, 17'(k + 1), 7'h7F, 1'b1, 7'h7F, 17'(k), 1'b1};
    vecs[8]  = '{1'b0, 17'h0,  7'h7F, 1'b1, 7'h7F, 17'h8,  1'b1};
    vecs[9]  = '{1'b0, 17'h0,  7'h7F, 1'b1, 7'h00, 17'h0,  1'b0};
    vecs[10] = '{1'b1, 17'h11, 7'h00, 1'b1, 7'h00, 17'h0,  1'b0};
    vecs[11] = '{1'b1, 17'h12, 7'h00, 1'b1, 7'h7F, 17'h11, 1'b1};
    vecs[12] = '{1'b1, 17'h13, 7'h00, 1'b0, 7'h7F, 17'h11, 1'b1};
    vecs[13] = '{1'b1, 17'h13, 7'h7F, 1'b0, 7'h7F, 17'h11, 1'b1};
    vecs[14] = '{1'b1, 17'h13, 7'h7F, 1'b1, 7'h7F, 17'h12, 1'b1};
    vecs[15] = '{1'b0, 17'h0,  7'h7F, 1'b1, 7'h7F, 17'h13, 1'b1};
    vecs[16] = '{1'b0, 17'h0,  7'h7F, 1'b1, 7'h00, 17'h0,  1'b0};

    served = '0;
    rst_n  = 1'b0;
    drive(1'b0, '0, 7'h7F, 7'h7F, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset valid_out", 32'(valid_out), 32'h0);
    check("reset ready_out", 32'(ready_out), 32'h1);
    check("reset data_out", 32'(data_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].vin, vecs[i].din, 7'h7F, 7'h7F, vecs[i].rdy, 1'b0);
      settle($sformatf("vec%0d", i));
      check($sformatf("vec%0d ready_out", i), 32'(ready_out), 32'(vecs[i].exp_ro));
      check($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_vo));
      if (vecs[i].chk_do) check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_do));
      advance();
    end

    // Staggered accept: branch 0 takes at cycle 1, branch 1 only at cycle 4.
    rx0 = 0;
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, 17'hABCD, 7'h7F, 7'h03,
            (c == 1) ? 7'h01 : ((c == 4) ? 7'h02 : 7'h00), 1'b0);
      settle($sformatf("stagger c%0d", c));
      if (valid_out[0] && ready_in[0]) rx0++;
      if (c == 1) check("stagger c1 valid_out", 32'(valid_out), 32'h03);
      if (c == 2) check("stagger c2 valid_out", 32'(valid_out), 32'h02);
      if (c == 4) check("stagger c4 valid_out", 32'(valid_out), 32'h02);
      if (c == 5) check("stagger c5 valid_out", 32'(valid_out), 32'h00);
      advance();
    end
    check("stagger branch0 deliveries", 32'(rx0), 32'd1);

    // No active branch: the token is discarded; the buffer is empty again after.
    drive(1'b1, 17'h1234, 7'h00, 7'h7F, 7'h00, 1'b0);
    settle("noact push");
    advance();
    drive(1'b0, 17'h0, 7'h00, 7'h7F, 7'h00, 1'b0);
    settle("noact c1");
    check("noact c1 valid_out", 32'(valid_out), 32'h0);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 17'(17'h21 + c), 7'h7F, 7'h7F, 7'h00, 1'b0);
      settle($sformatf("noact refill c%0d", c));
      if (c == 2) begin
        check("noact refill full", 32'(ready_out), 32'h0);
        check("noact refill head", 32'(data_out), 32'h21);
      end
      advance();
    end
    drive(1'b0, 17'h0, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    settle("noact drain0");
    advance();
    settle("noact drain1");
    advance();

    // Config change mid-token: branch 2 is dropped after branch 0 has taken.
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, 17'h55, (c >= 2) ? 7'h7B : 7'h7F, 7'h05, (c == 1) ? 7'h01 : 7'h00, 1'b0);
      settle($sformatf("cfg c%0d", c));
      if (c == 1) check("cfg c1 valid_out", 32'(valid_out), 32'h05);
      if (c == 2) check("cfg c2 valid_out", 32'(valid_out), 32'h00);
      if (c == 3) check("cfg c3 ready_out", 32'(ready_out), 32'h1);
      advance();
    end

    // Flush, then asynchronous reset, with 2 tokens buffered and done = 7'h01.
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c <= 2; c++) begin
        drive(c < 2, 17'(17'h70 + c), 7'h7F, 7'h7F, (c == 2) ? 7'h01 : 7'h00, 1'b0);
        settle($sformatf("fl%0d c%0d", pass, c));
        advance();
      end
      drive(1'b0, 17'h0, 7'h7F, 7'h7F, 7'h00, pass == 0);
      settle($sformatf("fl%0d pre", pass));
      check($sformatf("fl%0d pre valid_out", pass), 32'(valid_out), 32'h7E);
      if (pass == 0) begin
        advance();
      end else begin
        rst_n = 1'b0;
        #1;
        q.delete();
        served = '0;
        check("rst async valid_out", 32'(valid_out), 32'h0);
        check("rst async ready_out", 32'(ready_out), 32'h1);
        check("rst async data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive(1'b0, 17'h0, 7'h7F, 7'h7F, 7'h00, 1'b0);
      settle($sformatf("fl%0d post", pass));
      check($sformatf("fl%0d post valid_out", pass), 32'(valid_out), 32'h0);
      check($sformatf("fl%0d post ready_out", pass), 32'(ready_out), 32'h1);
      advance();
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      drive(1'($urandom), 17'($urandom), 7'($urandom), 7'($urandom | 32'h11),
            7'($urandom | $urandom), $urandom_range(0, 31) == 0);
      settle($sformatf("rand c%0d", c));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
